// File: rtl/fp32_seq_subtractor_if.sv
// Operand/result handshake bundle for fp32_seq_subtractor.
// master drives operands and out_ready; slave is the subtractor.
interface fp32_seq_subtractor_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] S;
  logic        Overflow;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, S, Overflow, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, S, Overflow, out_valid
  );
endinterface

// File: rtl/fp32_seq_subtractor.sv
// Multi-cycle FP32 subtractor S = a - b with one-bit-per-cycle align/normalise.
// Define FP32_SUB_RNE_EN for round-to-nearest-even; default is truncation.
module fp32_seq_subtractor (
  input  logic                        clk,
  input  logic                        rst_n,
  fp32_seq_subtractor_if.slave        bus
);
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b;
  logic        x_sign, y_sign;
  logic [8:0]  x_exp;
  logic [26:0] x_man, y_man;
  logic [7:0]  diff;
  logic [31:0] s_q;
  logic        ovf_q;

  logic [7:0]  exp_a, exp_b, unpack_diff;
  logic        special, a_big;
  logic [26:0] man_a, man_b;
  logic [27:0] sum;
  logic [26:0] add_man;

  function automatic logic [32:0] round_pack(input logic sign, input logic [8:0] exp_in,
                                             input logic [26:0] man);
    logic [24:0] t;
    logic [8:0]  e;
    logic        inc;
    e = exp_in;
`ifdef FP32_SUB_RNE_EN
    inc = man[2] & (man[1] | man[0] | man[3]);
`else
    inc = 1'b0;
`endif
    t = {1'b0, man[26:3]} + {24'd0, inc};
    if (t[24]) begin
      t = t >> 1;
      e = e + 9'd1;
    end
    if (e >= 9'd255) return {1'b1, 32'h7F80_0000};
    return {1'b0, sign, e[7:0], t[22:0]};
  endfunction

  // op_b already carries the inverted sign, so everything below is a plain add
  assign exp_a       = op_a[30:23];
  assign exp_b       = op_b[30:23];
  assign special     = (exp_a == 8'hFF) || (exp_b == 8'hFF);
  assign a_big       = op_a[30:0] >= op_b[30:0];
  assign man_a       = (exp_a == 8'd0) ? 27'd0 : {1'b1, op_a[22:0], 3'b000};
  assign man_b       = (exp_b == 8'd0) ? 27'd0 : {1'b1, op_b[22:0], 3'b000};
  assign unpack_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);

  assign sum     = (x_sign == y_sign) ? ({1'b0, x_man} + {1'b0, y_man})
                                      : ({1'b0, x_man} - {1'b0, y_man});
  assign add_man = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.Overflow  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Exits are taken on the last shift so ALIGN costs d cycles and NORM n cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = UNPACK;
      UNPACK:  if (special) state_nxt = DONE;
               else if (unpack_diff == 8'd0) state_nxt = ADD;
               else state_nxt = ALIGN;
      ALIGN:   if (diff > 8'd26 || diff == 8'd1) state_nxt = ADD;
      ADD:     if (sum == 28'd0) state_nxt = DONE;
               else if (add_man[26]) state_nxt = ROUND;
               else state_nxt = NORM;
      NORM:    if (x_exp == 9'd1) state_nxt = DONE;
               else if (x_man[25]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      x_sign <= 1'b0;
      y_sign <= 1'b0;
      x_exp  <= 9'd0;
      x_man  <= 27'd0;
      y_man  <= 27'd0;
      diff   <= 8'd0;
      s_q    <= 32'd0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_a <= bus.a;
          op_b <= {~bus.b[31], bus.b[30:0]};
        end
        UNPACK: begin
          if (special) begin
            s_q   <= 32'h7F80_0000;
            ovf_q <= 1'b1;
          end else begin
            ovf_q  <= 1'b0;
            diff   <= unpack_diff;
            x_sign <= a_big ? op_a[31] : op_b[31];
            y_sign <= a_big ? op_b[31] : op_a[31];
            x_exp  <= {1'b0, a_big ? exp_a : exp_b};
            x_man  <= a_big ? man_a : man_b;
            y_man  <= a_big ? man_b : man_a;
          end
        end
        ALIGN: begin
          if (diff > 8'd26) begin
            y_man <= {26'd0, |y_man};
            diff  <= 8'd0;
          end else begin
            y_man <= {1'b0, y_man[26:2], y_man[1] | y_man[0]};
            diff  <= diff - 8'd1;
          end
        end
        ADD: begin
          x_man <= add_man;
          x_exp <= x_exp + {8'd0, sum[27]};
          if (sum == 28'd0) s_q <= 32'd0;
        end
        NORM: begin
          x_man <= {x_man[25:0], 1'b0};
          x_exp <= x_exp - 9'd1;
          if (x_exp == 9'd1) s_q <= {x_sign, 31'd0};
        end
        ROUND:   {ovf_q, s_q} <= round_pack(x_sign, x_exp, x_man);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_seq_subtractor.sv
// Self-checking bench for fp32_seq_subtractor: directed vectors, handshake,
// reset abort and randomized operands against an exact-arithmetic model.
module tb_fp32_seq_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fp32_seq_subtractor_if bus ();

  fp32_seq_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Exact reference: align on an 80-bit integer grid, then round once.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output logic ov, output int lat);
    logic [31:0] bn, x, y;
    logic [7:0]  ex, ey;
    logic [23:0] mx, my;
    logic [79:0] big, ysh, nrm;
    logic [24:0] man;
    int          dd, p, e, n, d;
    bn  = {~b[31], b[30:0]};
    lat = -1;
    ov  = 1'b0;
    s   = 32'd0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      s = 32'h7F80_0000; ov = 1'b1; lat = 2;
      return;
    end
    if (a[30:0] >= bn[30:0]) begin x = a; y = bn; end
    else begin x = bn; y = a; end
    ex = x[30:23];
    ey = y[30:23];
    mx = (ex == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my = (ey == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    dd = int'(ex) - int'(ey);
    if (dd > 40) ysh = (my != 24'd0) ? 80'd1 : 80'd0;
    else         ysh = {56'd0, my} << (40 - dd);
    big = {56'd0, mx} << 40;
    big = (x[31] == y[31]) ? big + ysh : big - ysh;
    if (big == 80'd0) return;
    p = 0;
    for (int i = 0; i < 80; i++) if (big[i]) p = i;
    e = int'(ex) + p - 63;
    if (e <= 0) begin
      s = {x[31], 31'd0};
      return;
    end
    nrm = big << (79 - p);
    man = {1'b0, nrm[79:56]};
`ifdef FP32_SUB_RNE_EN
    if (nrm[55] && ((|nrm[54:0]) || man[0])) man = man + 25'd1;
    if (man[24]) begin man = man >> 1; e = e + 1; end
`endif
    n   = (p >= 63) ? 0 : 63 - p;
    d   = (dd > 26) ? 1 : dd;
    lat = 4 + d + n;
    if (e >= 255) begin s = 32'h7F80_0000; ov = 1'b1; end
    else s = {x[31], e[7:0], man[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] s, output logic ov, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin lat = c; break; end
    end
    if (lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout a=%h b=%h: out_valid never rose within 200 cycles", a, b);
    end
    s  = bus.S;
    ov = bus.Overflow;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.a = 32'd0; bus.b = 32'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_checks++; if (bus.S !== 32'd0) begin n_fail++; $display("FAIL reset_S got=%h want=00000000", bus.S); end
    n_checks++; if (bus.Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_Overflow got=%b want=0", bus.Overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] va [6] = '{32'h42B40000, 32'h40000000, 32'hC01D0E56, 32'hFFE872B0, 32'h42340000, 32'h7F7FFFFF};
    logic [31:0] vb [6] = '{32'h42340000, 32'h40000000, 32'h40000000, 32'h42340000, 32'hFFE872B0, 32'hFF7FFFFF};
    logic [31:0] vs [6] = '{32'h42340000, 32'h00000000, 32'hC08E872B, 32'h7F800000, 32'h7F800000, 32'h7F800000};
    logic        vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          vl [6] = '{6, -1, 4, 2, 2, 4};
    logic [31:0] s;
    logic        ov;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], s, ov, lat);
      n_checks++; if (s !== vs[i]) begin n_fail++; $display("FAIL directed_S[%0d] got=%h want=%h", i, s, vs[i]); end
      n_checks++; if (ov !== vo[i]) begin n_fail++; $display("FAIL directed_Overflow[%0d] got=%b want=%b", i, ov, vo[i]); end
      if (vl[i] >= 0) begin
        n_checks++; if (lat != vl[i]) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, vl[i]); end
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] s_first;
    int          lat = 0;
    @(negedge clk);
    bus.a = 32'h42B40000; bus.b = 32'h42340000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin lat = c; break; end
    end
    n_checks++; if (lat == 0) begin n_fail++; $display("FAIL hold_timeout got=no out_valid want=out_valid"); end
    s_first = bus.S;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.S !== 32'h42340000) begin n_fail++; $display("FAIL hold_S[%0d] got=%h want=42340000 (first=%h)", k, bus.S, s_first); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got=%b want=0", k, bus.in_ready); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid[%0d] got=%b want=1", k, bus.out_valid); end
      bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL after_consume_in_ready got=%b want=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL after_consume_out_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] s, ms;
    logic        ov, mo;
    int          lat, ml;
    @(negedge clk);
    bus.a = 32'h3F800000; bus.b = 32'h33800000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got=%b want=0", bus.out_valid); end
    n_checks++; if (bus.S !== 32'd0) begin n_fail++; $display("FAIL abort_S got=%h want=00000000", bus.S); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h3F800000, 32'h33800000, s, ov, lat);
    model(32'h3F800000, 32'h33800000, ms, mo, ml);
    n_checks++; if (s !== ms) begin n_fail++; $display("FAIL post_abort_S got=%h want=%h", s, ms); end
    n_checks++; if (ov !== mo) begin n_fail++; $display("FAIL post_abort_Overflow got=%b want=%b", ov, mo); end
    n_checks++; if (lat != ml) begin n_fail++; $display("FAIL post_abort_latency got=%0d want=%0d", lat, ml); end
  endtask

  task automatic test_random;
    logic [31:0] a, b, s, ms;
    logic        ov, mo;
    int          lat, ml, ea, eb, mode;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0)      ea = $urandom_range(1, 4);
      else if ($urandom_range(0, 9) == 0) ea = $urandom_range(250, 254);
      else                                ea = $urandom_range(100, 160);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       eb = ea;
        1:       eb = ea - $urandom_range(0, 40);
        2:       eb = ea + $urandom_range(0, 3);
        default: eb = $urandom_range(1, 254);
      endcase
      if (eb < 0)   eb = 0;
      if (eb > 254) eb = 254;
      if ($urandom_range(0, 19) == 0) ea = 255;
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      if (mode == 0 && $urandom_range(0, 1) == 1) b[22:0] = a[22:0] ^ 23'($urandom_range(0, 15));
      run_op(a, b, s, ov, lat);
      model(a, b, ms, mo, ml);
      n_checks++; if (s !== ms) begin n_fail++; $display("FAIL random_S[%0d] a=%h b=%h got=%h want=%h", i, a, b, s, ms); end
      n_checks++; if (ov !== mo) begin n_fail++; $display("FAIL random_Overflow[%0d] a=%h b=%h got=%b want=%b", i, a, b, ov, mo); end
      if (ml >= 0) begin
        n_checks++; if (lat != ml) begin n_fail++; $display("FAIL random_latency[%0d] a=%h b=%h got=%0d want=%0d", i, a, b, lat, ml); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
